nibble_bus_ctrl: RTL and testbench
==================================

# nibble_bus_ctrl

Sequencer and arbiter for the shared 4-bit external memory port of the TinyTapeout CPU. The address leaves on io_out[3:0] and the data returns on io_in[7:4]. The block serves two requesters, instruction fetch (f_) and operand read (d_). It round-robins the single port between them, inserts configurable wait states, and optionally assembles bytes from two consecutive nibbles. The CPU's micro-sequencer talks only to this block; the block is the only driver of the memory pins.

## Interface
Parameters:
- WAIT_CYCLES, 0, extra cycles mem_addr is held before mem_data is sampled (0–7; 3-bit counter).

Ports:
- clk  in  1  core clock (io_in[0])
- reset  in  1  synchronous, active-high reset (io_in[1])
- f_req  in  1  fetch request, held until f_ack
- f_addr  in  4  fetch nibble address
- f_size  in  1  0 = nibble, 1 = byte
- f_ack  out  1  one-cycle pulse; rdata valid this cycle
- d_req, d_addr, d_size, d_ack  same as f_* for the operand requester
- rdata  out  8  read result, registered
- mem_addr  out  4  to io_out[3:0], registered
- mem_data  in  4  from io_in[7:4]
- mem_rd  out  1  high while a memory access is in flight (WAIT state)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WAIT, ACK.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not granted last. After reset, fetch wins the first tie.
  - On grant: latch id, addr and size; mem_addr <= addr; cnt <= WAIT_CYCLES; phase <= 0; go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0 and phase == 0: rdata[3:0] <= mem_data.
    - If size == 1: mem_addr <= addr+1 (mod 16, so 15 wraps to 0); cnt <= WAIT_CYCLES; phase <= 1; stay in WAIT.
    - Otherwise: rdata[7:4] <= 0; go to ACK.
  - If cnt == 0 and phase == 1: rdata[7:4] <= mem_data; go to ACK.
- ACK: assert the granted requester's ack for exactly one cycle; go to IDLE.
- mem_addr holds its last value outside transactions.
- rdata holds its value until the next capture.
- Requester rules:
  - Keep req, addr and size stable from assertion until ack.
  - Drop req in the cycle after ack. If req is still high then, it is taken as a new request.
  - Dropping req before ack is illegal. A granted transaction always completes and acks.
- f_ack and d_ack are never high in the same cycle.

## Timing
- Cycle 0: req sampled high in IDLE.
- Cycle 1: mem_addr valid.
- Nibble: mem_data sampled at the end of cycle 1+WAIT_CYCLES; ack in cycle 2+WAIT_CYCLES.
- Byte: ack in cycle 3+2·WAIT_CYCLES.
- Back-to-back: the next grant is earliest in the cycle after ack, so nibbles at WAIT_CYCLES=0 issue at one per 3 cycles.
- Reset (synchronous, dominates all states, including mid-transaction):
  - Return to IDLE; abort without ack.
  - f_ack = d_ack = 0, rdata = 0, mem_addr = 0, mem_rd = 0, busy = 0.
  - Round-robin pointer set so fetch wins the next tie.

## Configuration
- NIBBLE_BUS_CTRL_BYTE_EN defined: byte reads supported as described.
- Not defined:
  - f_size and d_size are ignored; every access is a nibble and rdata[7:4] = 0.
  - Phase logic is removed.
  - Byte latency never occurs.

## Test plan
Bench memory returns mem_data = addr ^ 4'hA, combinationally.
- Fetch nibble at f_addr=3, WAIT_CYCLES=0 → mem_addr=3 in cycle 1; f_ack in cycle 2 with rdata=8'h09; d_ack stays 0.
- Byte read at d_addr=15, macro defined, WAIT_CYCLES=0 → mem_addr sequence 15, 0; d_ack in cycle 3 with rdata=8'hA5.
- f_req and d_req both held for 4 transactions, addrs 1 and 2 → grants F, D, F, D; rdata 8'h0B, 8'h08, 8'h0B, 8'h08; acks never overlap.
- WAIT_CYCLES=3, nibble at addr 6 → mem_addr=6 stable for cycles 1–4; mem_rd high in cycles 1–4; ack in cycle 5 with rdata=8'h0C.
- Reset asserted in the cycle after a byte grant → next cycle is IDLE, all outputs 0, no ack; a fetch request after reset wins a tie against a simultaneous operand request.
- Macro undefined, d_size=1 at addr 7 → single nibble access; ack in cycle 2 with rdata=8'h0D.

Source files
------------

// File: rtl/nibble_bus_ctrl.sv
// Round-robin sequencer for the shared 4-bit memory port (fetch vs operand).
// Define NIBBLE_BUS_CTRL_BYTE_EN to assemble bytes from two consecutive nibbles.
module nibble_bus_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       f_req,
  input  logic [3:0] f_addr,
  input  logic       f_size,
  output logic       f_ack,
  input  logic       d_req,
  input  logic [3:0] d_addr,
  input  logic       d_size,
  output logic       d_ack,
  output logic [7:0] rdata,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  output logic       mem_rd,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       id_q, id_d;
  logic [3:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       grant_f, grant_d;

`ifdef NIBBLE_BUS_CTRL_BYTE_EN
  logic       size_q, size_d;
  logic       phase_q, phase_d;
`else
  logic       unused_size;
  assign unused_size = f_size ^ d_size;
`endif

  // A tie goes to whichever requester was not served last.
  assign grant_f = f_req & (~d_req | last_d_q);
  assign grant_d = d_req & ~grant_f;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    id_d       = id_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
`ifdef NIBBLE_BUS_CTRL_BYTE_EN
    size_d     = size_q;
    phase_d    = phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_f || grant_d) begin
          id_d       = grant_d;
          last_d_d   = grant_d;
          addr_d     = grant_d ? d_addr : f_addr;
          mem_addr_d = grant_d ? d_addr : f_addr;
          cnt_d      = WAIT_INIT;
          state_d    = S_WAIT;
`ifdef NIBBLE_BUS_CTRL_BYTE_EN
          size_d     = grant_d ? d_size : f_size;
          phase_d    = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
`ifdef NIBBLE_BUS_CTRL_BYTE_EN
          if (!phase_q) begin
            rdata_d[3:0] = mem_data;
            if (size_q) begin
              mem_addr_d = addr_q + 4'd1;
              cnt_d      = WAIT_INIT;
              phase_d    = 1'b1;
            end else begin
              rdata_d[7:4] = 4'h0;
              state_d      = S_ACK;
            end
          end else begin
            rdata_d[7:4] = mem_data;
            state_d      = S_ACK;
          end
`else
          rdata_d = {4'h0, mem_data};
          state_d = S_ACK;
`endif
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_d_q   <= 1'b1;
      mem_addr_q <= 4'h0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Transaction context needs no reset: it is rewritten on every grant.
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
`ifdef NIBBLE_BUS_CTRL_BYTE_EN
    size_q  <= size_d;
    phase_q <= phase_d;
`endif
  end

  assign f_ack    = (state_q == S_ACK) && !id_q;
  assign d_ack    = (state_q == S_ACK) &&  id_q;
  assign mem_rd   = (state_q == S_WAIT);
  assign busy     = (state_q != S_IDLE);
  assign mem_addr = mem_addr_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_nibble_bus_ctrl.sv
// Scoreboard bench for nibble_bus_ctrl: WAIT_CYCLES=0 and WAIT_CYCLES=3 instances,
// memory model returns addr ^ 4'hA.
module tb_nibble_bus_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       f_req, f_size, d_req, d_size;
  logic [3:0] f_addr, d_addr;
  logic       f_ack, d_ack, mem_rd, busy;
  logic [7:0] rdata;
  logic [3:0] mem_addr, mem_data;

  logic       f_req3, f_size3, d_req3, d_size3;
  logic [3:0] f_addr3, d_addr3;
  logic       f_ack3, d_ack3, mem_rd3, busy3;
  logic [7:0] rdata3;
  logic [3:0] mem_addr3, mem_data3;

  assign mem_data  = mem_addr  ^ 4'hA;
  assign mem_data3 = mem_addr3 ^ 4'hA;

  nibble_bus_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_size(f_size), .f_ack(f_ack),
    .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_ack(d_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rd(mem_rd), .busy(busy)
  );

  nibble_bus_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .f_req(f_req3), .f_addr(f_addr3), .f_size(f_size3), .f_ack(f_ack3),
    .d_req(d_req3), .d_addr(d_addr3), .d_size(d_size3), .d_ack(d_ack3),
    .rdata(rdata3), .mem_addr(mem_addr3), .mem_data(mem_data3),
    .mem_rd(mem_rd3), .busy(busy3)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected {is_operand, rdata} per ack, in issue order.
  logic [8:0] q0[$];
  logic [8:0] q3[$];

`ifdef NIBBLE_BUS_CTRL_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  always @(negedge clk) begin
    logic [8:0] e0, e3;
    if (f_ack || d_ack) begin
      n_cmp++;
      if (f_ack && d_ack) begin
        n_err++; $display("FAIL ack_overlap0: f_ack=%b d_ack=%b, required one", f_ack, d_ack);
      end else if (q0.size() == 0) begin
        n_err++; $display("FAIL unexpected_ack0: got d=%b rdata=%h, none required", d_ack, rdata);
      end else begin
        e0 = q0.pop_front();
        if ({d_ack, rdata} !== e0) begin
          n_err++; $display("FAIL sb0: got d=%b rdata=%h, required d=%b rdata=%h", d_ack, rdata, e0[8], e0[7:0]);
        end
      end
    end
    if (f_ack3 || d_ack3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_err++; $display("FAIL unexpected_ack3: got rdata=%h, none required", rdata3);
      end else begin
        e3 = q3.pop_front();
        if ({d_ack3, rdata3} !== e3) begin
          n_err++; $display("FAIL sb3: got d=%b rdata=%h, required d=%b rdata=%h", d_ack3, rdata3, e3[8], e3[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({f_ack, d_ack, rdata, mem_addr, mem_rd, busy} !== 16'h0) begin
      n_err++; $display("FAIL reset0: outputs=%h, required 0", {f_ack, d_ack, rdata, mem_addr, mem_rd, busy});
    end
    n_cmp++;
    if ({f_ack3, d_ack3, rdata3, mem_addr3, mem_rd3, busy3} !== 16'h0) begin
      n_err++; $display("FAIL reset3: outputs=%h, required 0", {f_ack3, d_ack3, rdata3, mem_addr3, mem_rd3, busy3});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int acks = 0;
    logic [3:0] seq = 4'h0;
    f_req = 1'b1; f_addr = 4'd1; f_size = 1'b0;
    d_req = 1'b1; d_addr = 4'd2; d_size = 1'b0;
    q0.push_back({1'b0, 8'h0B}); q0.push_back({1'b1, 8'h08});
    q0.push_back({1'b0, 8'h0B}); q0.push_back({1'b1, 8'h08});
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick();
      if (f_ack || d_ack) begin
        acks++;
        seq = {seq[2:0], d_ack};
      end
    end
    n_cmp++;
    if (acks != 4) begin
      n_err++; $display("FAIL rr_timeout: acks=%0d, required 4", acks);
    end
    n_cmp++;
    if (seq !== 4'b0101) begin
      n_err++; $display("FAIL rr_order: seq=%b, required 0101", seq);
    end
    tick();
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fetch_nibble();
    f_req = 1'b1; f_addr = 4'd3; f_size = 1'b0;
    q0.push_back({1'b0, 8'h09});
    tick();
    n_cmp++;
    if (mem_addr !== 4'd3 || mem_rd !== 1'b1 || f_ack !== 1'b0) begin
      n_err++; $display("FAIL fetch_c1: mem_addr=%h mem_rd=%b f_ack=%b, required 3 1 0", mem_addr, mem_rd, f_ack);
    end
    tick();
    n_cmp++;
    if (f_ack !== 1'b1 || d_ack !== 1'b0 || rdata !== 8'h09) begin
      n_err++; $display("FAIL fetch_c2: f_ack=%b d_ack=%b rdata=%h, required 1 0 09", f_ack, d_ack, rdata);
    end
    tick();
    f_req = 1'b0;
    n_cmp++;
    if (f_ack !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL fetch_c3: f_ack=%b busy=%b, required 0 0", f_ack, busy);
    end
    tick();
  endtask

  task automatic test_byte_wrap();
    d_req = 1'b1; d_addr = 4'd15; d_size = 1'b1;
    q0.push_back({1'b1, BYTE_EN ? 8'hA5 : 8'h05});
    tick();
    n_cmp++;
    if (mem_addr !== 4'd15 || d_ack !== 1'b0) begin
      n_err++; $display("FAIL byte_c1: mem_addr=%h d_ack=%b, required f 0", mem_addr, d_ack);
    end
    tick();
    n_cmp++;
    if (BYTE_EN && (mem_addr !== 4'd0 || d_ack !== 1'b0)) begin
      n_err++; $display("FAIL byte_c2: mem_addr=%h d_ack=%b, required 0 0", mem_addr, d_ack);
    end else if (!BYTE_EN && (d_ack !== 1'b1 || rdata !== 8'h05)) begin
      n_err++; $display("FAIL byte_c2: d_ack=%b rdata=%h, required 1 05", d_ack, rdata);
    end
    if (BYTE_EN) begin
      tick();
      n_cmp++;
      if (d_ack !== 1'b1 || rdata !== 8'hA5) begin
        n_err++; $display("FAIL byte_c3: d_ack=%b rdata=%h, required 1 a5", d_ack, rdata);
      end
    end
    tick();
    d_req = 1'b0; d_size = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    f_req3 = 1'b1; f_addr3 = 4'd6; f_size3 = 1'b0;
    q3.push_back({1'b0, 8'h0C});
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if (mem_addr3 !== 4'd6 || mem_rd3 !== 1'b1 || f_ack3 !== 1'b0) begin
        n_err++; $display("FAIL wait_c%0d: mem_addr=%h mem_rd=%b f_ack=%b, required 6 1 0", c, mem_addr3, mem_rd3, f_ack3);
      end
    end
    tick();
    n_cmp++;
    if (f_ack3 !== 1'b1 || rdata3 !== 8'h0C || mem_rd3 !== 1'b0) begin
      n_err++; $display("FAIL wait_c5: f_ack=%b rdata=%h mem_rd=%b, required 1 0c 0", f_ack3, rdata3, mem_rd3);
    end
    tick();
    f_req3 = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int c;
    f_req = 1'b1; f_addr = 4'd5; f_size = 1'b1;
    tick();
    reset = 1'b1; f_req = 1'b0;
    tick();
    n_cmp++;
    if ({f_ack, d_ack, rdata, mem_addr, mem_rd, busy} !== 16'h0) begin
      n_err++; $display("FAIL abort: outputs=%h, required 0", {f_ack, d_ack, rdata, mem_addr, mem_rd, busy});
    end
    reset = 1'b0; f_size = 1'b0;
    tick();
    f_req = 1'b1; f_addr = 4'd4;
    d_req = 1'b1; d_addr = 4'd9; d_size = 1'b0;
    q0.push_back({1'b0, 8'h0E}); q0.push_back({1'b1, 8'h03});
    c = 0;
    do begin tick(); c++; end while (!(f_ack || d_ack) && c < 20);
    n_cmp++;
    if (f_ack !== 1'b1) begin
      n_err++; $display("FAIL tie_after_reset: f_ack=%b d_ack=%b, required fetch first", f_ack, d_ack);
    end
    tick();
    f_req = 1'b0;
    c = 0;
    while (!d_ack && c < 20) begin tick(); c++; end
    n_cmp++;
    if (d_ack !== 1'b1) begin
      n_err++; $display("FAIL tie_second: d_ack=%b, required 1", d_ack);
    end
    tick();
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_size_ignored();
    d_req = 1'b1; d_addr = 4'd7; d_size = 1'b1;
    q0.push_back({1'b1, BYTE_EN ? 8'h2D : 8'h0D});
    tick(); tick();
    n_cmp++;
    if (d_ack !== !BYTE_EN) begin
      n_err++; $display("FAIL size_c2: d_ack=%b, required %b", d_ack, !BYTE_EN);
    end
    if (BYTE_EN) tick();
    n_cmp++;
    if (d_ack !== 1'b1 || rdata !== (BYTE_EN ? 8'h2D : 8'h0D)) begin
      n_err++; $display("FAIL size_ack: d_ack=%b rdata=%h, required 1 %h", d_ack, rdata, BYTE_EN ? 8'h2D : 8'h0D);
    end
    tick();
    d_req = 1'b0; d_size = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = 4'h0; f_size = 1'b0;
    d_req = 1'b0; d_addr = 4'h0; d_size = 1'b0;
    f_req3 = 1'b0; f_addr3 = 4'h0; f_size3 = 1'b0;
    d_req3 = 1'b0; d_addr3 = 4'h0; d_size3 = 1'b0;
    test_reset();
    test_round_robin();
    test_fetch_nibble();
    test_byte_wrap();
    test_wait_states();
    test_reset_abort();
    test_size_ignored();
    tick(); tick();
    n_cmp++;
    if (q0.size() != 0 || q3.size() != 0) begin
      n_err++; $display("FAIL sb_drain: pending=%0d/%0d, required 0/0", q0.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
